// File: rtl/pe_rx_cpu.sv
// CPU-side receive agent: polls the NIC input-channel status through the shared
// register port and drains each delivered packet, keeping receive and misroute statistics.
module pe_rx_cpu #(
   parameter int PACKET_WIDTH = 64,
   parameter int POLL_GAP     = 4,
   parameter int CNT_WIDTH    = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    enable,
   input  logic [3:0]              node_position,
   output logic [1:0]              addr,
   output logic                    nicEn,
   output logic                    nicEnWR,
   input  logic [PACKET_WIDTH-1:0] d_out,
   output logic                    pkt_valid,
   output logic [PACKET_WIDTH-1:0] last_pkt,
   output logic [CNT_WIDTH-1:0]    rx_count,
   output logic [CNT_WIDTH-1:0]    misroute_count
);

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_WAIT = 2'b01,
      S_POLL = 2'b10,
      S_READ = 2'b11
   } state_t;

   localparam logic [7:0]           GAP_LOAD = 8'(POLL_GAP);
   localparam logic [1:0]           ADDR_IN_BUF = 2'b00;
   localparam logic [1:0]           ADDR_IN_STAT = 2'b01;
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   state_t                   state_q, state_d;
   logic [7:0]               gap_cnt_q, gap_cnt_d;
   logic                     pkt_valid_q, pkt_valid_d;
   logic [PACKET_WIDTH-1:0]  last_pkt_q, last_pkt_d;
   logic [CNT_WIDTH-1:0]     rx_count_q, rx_count_d;
   logic [CNT_WIDTH-1:0]     misroute_count_q, misroute_count_d;
   logic [1:0]               addr_s;
   logic                     nic_en_s;
   logic                     misrouted_s;

   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] value);
      logic [CNT_WIDTH-1:0] result;
      if (value == {CNT_WIDTH{1'b1}}) begin
         result = value;
      end else begin
         result = value + CNT_ONE;
      end
      return result;
   endfunction

   // Next-state logic; POLL and READ always run to completion regardless of enable.
   always_comb begin
      state_d   = state_q;
      gap_cnt_d = gap_cnt_q;
      case (state_q)
         S_IDLE: begin
            if (enable) begin
               state_d   = S_WAIT;
               gap_cnt_d = GAP_LOAD;
            end else begin
               state_d   = S_IDLE;
            end
         end
         S_WAIT: begin
            if (gap_cnt_q == 8'd0) begin
               if (enable) begin
                  state_d = S_POLL;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               gap_cnt_d = gap_cnt_q - 8'd1;
            end
         end
         S_POLL: begin
            if (d_out[0]) begin
               state_d   = S_READ;
            end else begin
               state_d   = S_WAIT;
               gap_cnt_d = GAP_LOAD;
            end
         end
         S_READ: begin
            state_d   = S_WAIT;
            gap_cnt_d = GAP_LOAD;
         end
         default: begin
            state_d   = S_IDLE;
            gap_cnt_d = 8'd0;
         end
      endcase
   end

   // Capture path: the buffer word present during READ becomes last_pkt at the closing edge.
   always_comb begin
      misrouted_s      = (d_out[51:48] != node_position);
      pkt_valid_d      = 1'b0;
      last_pkt_d       = last_pkt_q;
      rx_count_d       = rx_count_q;
      misroute_count_d = misroute_count_q;
      if (state_q == S_READ) begin
         pkt_valid_d = 1'b1;
         last_pkt_d  = d_out;
         rx_count_d  = sat_inc(rx_count_q);
         if (misrouted_s) begin
            misroute_count_d = sat_inc(misroute_count_q);
         end else begin
            misroute_count_d = misroute_count_q;
         end
      end else begin
         pkt_valid_d = 1'b0;
      end
   end

   // NIC port decode from the registered state only, so addr/nicEn cannot glitch.
   always_comb begin
      addr_s   = ADDR_IN_BUF;
      nic_en_s = 1'b0;
      case (state_q)
         S_POLL: begin
            addr_s   = ADDR_IN_STAT;
            nic_en_s = 1'b1;
         end
         S_READ: begin
            addr_s   = ADDR_IN_BUF;
            nic_en_s = 1'b1;
         end
         default: begin
            addr_s   = ADDR_IN_BUF;
            nic_en_s = 1'b0;
         end
      endcase
   end

   // State and statistics registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q          <= S_IDLE;
         gap_cnt_q        <= 8'd0;
         pkt_valid_q      <= 1'b0;
         last_pkt_q       <= {PACKET_WIDTH{1'b0}};
         rx_count_q       <= {CNT_WIDTH{1'b0}};
         misroute_count_q <= {CNT_WIDTH{1'b0}};
      end else begin
         state_q          <= state_d;
         gap_cnt_q        <= gap_cnt_d;
         pkt_valid_q      <= pkt_valid_d;
         last_pkt_q       <= last_pkt_d;
         rx_count_q       <= rx_count_d;
         misroute_count_q <= misroute_count_d;
      end
   end

   assign addr           = addr_s;
   assign nicEn          = nic_en_s;
   assign nicEnWR        = 1'b0;
   assign pkt_valid      = pkt_valid_q;
   assign last_pkt       = last_pkt_q;
   assign rx_count       = rx_count_q;
   assign misroute_count = misroute_count_q;

endmodule
